// File: rtl/fire_pkg.sv
// Shared constants for the fire layers.
// Each layer's bias/ReLU/requant stage takes its geometry from here.
package fire_pkg;

    localparam int FIRE3_EXPAND3_NUM_CH = 64;
    localparam int FIRE3_EXPAND3_ACC_W  = 32;
    localparam int FIRE3_EXPAND3_OUT_W  = 16;
    localparam int FIRE3_EXPAND3_SHIFT  = 8;

    // Channel index width, never below one bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/relu_requant.sv
// Combinational ReLU + round-half-up requantiser with
// positive saturation, shared across the fire layers.
module relu_requant #(
    parameter int IN_W  = 33,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8
) (
    input  logic signed [IN_W-1:0]  sum,
    output logic        [OUT_W-1:0] act
);

    localparam logic [IN_W-1:0] RND =
        IN_W'(64'd1 << (SHIFT - 1));
    localparam logic [IN_W-1:0] MAX =
        IN_W'((64'd1 << (OUT_W - 1)) - 64'd1);

    logic [IN_W-1:0] rounded;
    logic [IN_W-1:0] shifted;

    // Non-negative magnitude plus rounding term; the top bit is
    // headroom so the rounding add cannot wrap.
    assign rounded = {1'b0, sum[IN_W-2:0]} + RND;
    assign shifted = rounded >> SHIFT;

    // Negative sums clamp to zero, large ones to the output max.
    always_comb begin
        act = '0;
        if (!sum[IN_W-1]) begin
            if (shifted > MAX) begin
                act = MAX[OUT_W-1:0];
            end else begin
                act = shifted[OUT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bias_relu_fire3_expand3.sv
// Bias add, ReLU and requantisation for fire3_expand3, as a
// two-stage valid/ready pipeline with channel tracking.
module bias_relu_fire3_expand3
    import fire_pkg::*;
#(
    parameter int NUM_CH = FIRE3_EXPAND3_NUM_CH,
    parameter int ACC_W  = FIRE3_EXPAND3_ACC_W,
    parameter int OUT_W  = FIRE3_EXPAND3_OUT_W,
    parameter int SHIFT  = FIRE3_EXPAND3_SHIFT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CH-1:0][ACC_W-1:0]          bias_mem,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [ACC_W-1:0]                      in_data,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_W-1:0]                      out_data,
    output logic [ch_width(NUM_CH)-1:0]           out_ch,
    output logic                                  out_last,
    output logic                                  err_sync
);

    localparam int CH_W = ch_width(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0]         ch;
    logic                    s1_valid;
    logic signed [ACC_W:0]   s1_sum;
    logic [CH_W-1:0]         s1_ch;
    logic [OUT_W-1:0]        rq_act;
    logic                    s1_adv;
    logic                    s2_adv;
    logic                    accept;
    logic [ACC_W-1:0]        bias_cur;
    logic                    at_last;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && in_ready;
    assign bias_cur = bias_mem[ch];
    assign at_last  = (ch == LAST_CH);

    // Channel counter and sticky in_last/channel mismatch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch       <= '0;
            err_sync <= 1'b0;
        end else if (accept) begin
            ch <= at_last ? '0 : ch + 1'b1;
            if (in_last != at_last) begin
                err_sync <= 1'b1;
            end
        end
    end

    // Stage 1: sign-extended bias add, one bit wider than ACC_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_ch    <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum <= $signed({in_data[ACC_W-1], in_data})
                        + $signed({bias_cur[ACC_W-1], bias_cur});
                s1_ch  <= ch;
            end
        end
    end

    relu_requant #(
        .IN_W  (ACC_W + 1),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_rq (
        .sum (s1_sum),
        .act (rq_act)
    );

    // Stage 2: registered activation, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= rq_act;
                out_ch   <= s1_ch;
                out_last <= (s1_ch == LAST_CH);
            end
        end
    end

endmodule
